// File: rtl/sim_mem_arbiter_if.sv
// Bundle of CPU-side channel signals and the external memory port seen by sim_mem_arbiter.
// Signal names carry the arbiter's point of view: i_* flow into it, o_* flow out of it.
interface sim_mem_arbiter_if #(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 12,
    parameter int CHANNELS   = 2
);
    logic [CHANNELS-1:0]            i_req;
    logic [CHANNELS*ADDR_WIDTH-1:0] i_addr;
    logic [CHANNELS-1:0]            i_we;
    logic [CHANNELS*DATA_WIDTH-1:0] i_wdata;
    logic [CHANNELS-1:0]            o_ack;
    logic                           o_err;
    logic [DATA_WIDTH-1:0]          o_rdata;
    logic                           o_mem_req;
    logic [ADDR_WIDTH-1:0]          o_mem_addr;
    logic                           o_mem_we;
    logic [DATA_WIDTH-1:0]          o_mem_wdata;
    logic                           i_mem_ack;
    logic [DATA_WIDTH-1:0]          i_mem_rdata;

    modport slave (
        input  i_req, i_addr, i_we, i_wdata, i_mem_ack, i_mem_rdata,
        output o_ack, o_err, o_rdata, o_mem_req, o_mem_addr, o_mem_we, o_mem_wdata
    );

    modport master (
        output i_req, i_addr, i_we, i_wdata, i_mem_ack, i_mem_rdata,
        input  o_ack, o_err, o_rdata, o_mem_req, o_mem_addr, o_mem_we, o_mem_wdata
    );
endinterface

// File: rtl/sim_mem_arbiter.sv
// Round-robin arbiter merging CHANNELS request channels onto one simulated memory port,
// with ack-driven wait states and an optional timeout that answers with o_err.
module sim_mem_arbiter #(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 12,
    parameter int CHANNELS   = 2,
    parameter int TIMEOUT    = 15
) (
    input logic               i_clk,
    input logic               i_rst,
    sim_mem_arbiter_if.slave  io_bus
);
    localparam int GW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
    localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CW-1:0] CNT_LAST   = (TIMEOUT > 0) ? CW'(TIMEOUT - 1) : '0;
    localparam logic [GW-1:0] GRANT_INIT = GW'(CHANNELS - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_DONE
    } state_t;

    state_t                r_state;
    state_t                w_next_state;
    logic [GW-1:0]         r_last_grant;
    logic [GW-1:0]         r_grant;
    logic [CW-1:0]         r_cnt;
    logic [CHANNELS-1:0]   r_ack;
    logic                  r_err;
    logic [DATA_WIDTH-1:0] r_rdata;
    logic                  r_mem_req;
    logic [ADDR_WIDTH-1:0] r_mem_addr;
    logic                  r_mem_we;
    logic [DATA_WIDTH-1:0] r_mem_wdata;
    logic [GW-1:0]         w_grant;
    logic                  w_any_req;
    logic                  w_timeout;

    // Scan from the furthest channel back toward last_grant+1 so the closest requester wins.
    always_comb begin
        int idx;
        // NOTE: every always_comb output gets a default first; a missed path would infer a latch.
        idx       = 0;
        w_any_req = 1'b0;
        w_grant   = '0;
        for (int k = CHANNELS; k >= 1; k--) begin
            idx = int'(r_last_grant) + k;
            if (idx >= CHANNELS) idx = idx - CHANNELS;
            if (io_bus.i_req[idx]) begin
                w_any_req = 1'b1;
                w_grant   = GW'(idx);
            end
        end
    end

    assign w_timeout = (TIMEOUT != 0) && (r_cnt == CNT_LAST);

    always_ff @(posedge i_clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (i_rst) r_state <= S_IDLE;
        else       r_state <= w_next_state;
    end

    always_comb begin
        w_next_state = r_state;
        unique case (r_state)
            S_IDLE:  if (w_any_req) w_next_state = S_ISSUE;
            S_ISSUE: if (io_bus.i_mem_ack || w_timeout) w_next_state = S_DONE;
            S_DONE:  w_next_state = S_IDLE;
            default: w_next_state = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_last_grant <= GRANT_INIT;
            r_grant      <= '0;
            r_cnt        <= '0;
            r_ack        <= '0;
            r_err        <= 1'b0;
            r_rdata      <= '0;
            r_mem_req    <= 1'b0;
            r_mem_addr   <= '0;
            r_mem_we     <= 1'b0;
            r_mem_wdata  <= '0;
        end else begin
            // Ack and err are single-cycle pulses; only the ISSUE exit raises them.
            r_ack <= '0;
            r_err <= 1'b0;
            unique case (r_state)
                S_IDLE: begin
                    if (w_any_req) begin
                        r_grant     <= w_grant;
                        r_mem_addr  <= io_bus.i_addr[int'(w_grant)*ADDR_WIDTH +: ADDR_WIDTH];
                        r_mem_we    <= io_bus.i_we[w_grant];
                        r_mem_wdata <= io_bus.i_wdata[int'(w_grant)*DATA_WIDTH +: DATA_WIDTH];
                        r_mem_req   <= 1'b1;
                        r_cnt       <= '0;
                    end
                end
                S_ISSUE: begin
                    if (io_bus.i_mem_ack) begin
                        if (!r_mem_we) r_rdata <= io_bus.i_mem_rdata;
                        r_ack     <= CHANNELS'(1) << r_grant;
                        r_mem_req <= 1'b0;
                    end else if (w_timeout) begin
                        r_ack     <= CHANNELS'(1) << r_grant;
                        r_err     <= 1'b1;
                        r_rdata   <= '1;
                        r_mem_req <= 1'b0;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                S_DONE: begin
                    r_last_grant <= r_grant;
                end
                default: ;
            endcase
        end
    end

    assign io_bus.o_ack       = r_ack;
    assign io_bus.o_err       = r_err;
    assign io_bus.o_rdata     = r_rdata;
    assign io_bus.o_mem_req   = r_mem_req;
    assign io_bus.o_mem_addr  = r_mem_addr;
    assign io_bus.o_mem_we    = r_mem_we;
    assign io_bus.o_mem_wdata = r_mem_wdata;
endmodule

// File: tb/tb_sim_mem_arbiter.sv
// Directed bench for sim_mem_arbiter: inputs change and outputs are sampled on the falling edge.
module tb_sim_mem_arbiter;
    logic clk;
    logic rst;
    int   total = 0;
    int   bad   = 0;

    sim_mem_arbiter_if #(.DATA_WIDTH(16), .ADDR_WIDTH(12), .CHANNELS(2)) bus ();

    sim_mem_arbiter #(
        .DATA_WIDTH(16), .ADDR_WIDTH(12), .CHANNELS(2), .TIMEOUT(15)
    ) dut (
        .i_clk (clk),
        .i_rst (rst),
        .io_bus(bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic set_ch(input int ch, input logic req, input logic we,
                          input logic [11:0] addr, input logic [15:0] wdata);
        bus.i_req[ch]             = req;
        bus.i_we[ch]              = we;
        bus.i_addr[ch*12 +: 12]   = addr;
        bus.i_wdata[ch*16 +: 16]  = wdata;
    endtask

    task automatic test_reset;
        logic [52:0] outs;
        rst             = 1'b1;
        bus.i_req       = '0;
        bus.i_addr      = '0;
        bus.i_we        = '0;
        bus.i_wdata     = '0;
        bus.i_mem_ack   = 1'b0;
        bus.i_mem_rdata = '0;
        repeat (2) @(negedge clk);
        outs = {bus.o_ack, bus.o_err, bus.o_rdata, bus.o_mem_req, bus.o_mem_addr,
                bus.o_mem_we, bus.o_mem_wdata};
        total++;
        if (outs !== '0) begin
            bad++;
            $display("FAIL reset_outputs: got %h want 0", outs);
        end
        rst = 1'b0;
    endtask

    task automatic test_single_read;
        set_ch(0, 1'b1, 1'b0, 12'h123, 16'h0000);
        bus.i_mem_ack   = 1'b1;
        bus.i_mem_rdata = 16'hBEEF;
        @(negedge clk);
        total++;
        if ({bus.o_mem_req, bus.o_mem_we, bus.o_mem_addr, bus.o_ack} !== {1'b1, 1'b0, 12'h123, 2'b00}) begin
            bad++;
            $display("FAIL read_issue: got req=%b we=%b addr=%h ack=%b want 1 0 123 00",
                     bus.o_mem_req, bus.o_mem_we, bus.o_mem_addr, bus.o_ack);
        end
        @(negedge clk);
        total++;
        if ({bus.o_ack, bus.o_err, bus.o_rdata} !== {2'b01, 1'b0, 16'hBEEF}) begin
            bad++;
            $display("FAIL read_ack: got ack=%b err=%b rdata=%h want 01 0 beef",
                     bus.o_ack, bus.o_err, bus.o_rdata);
        end
        set_ch(0, 1'b0, 1'b0, 12'h000, 16'h0000);
        bus.i_mem_ack = 1'b0;
        @(negedge clk);
        total++;
        if (bus.o_ack !== 2'b00) begin
            bad++;
            $display("FAIL read_ack_pulse: got ack=%b want 00", bus.o_ack);
        end
    endtask

    task automatic test_write_wait;
        set_ch(1, 1'b1, 1'b1, 12'h040, 16'h5A5A);
        bus.i_mem_ack = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            total++;
            if ({bus.o_mem_req, bus.o_mem_we, bus.o_mem_wdata, bus.o_mem_addr, bus.o_ack} !==
                {1'b1, 1'b1, 16'h5A5A, 12'h040, 2'b00}) begin
                bad++;
                $display("FAIL write_hold[%0d]: got req=%b we=%b wdata=%h addr=%h ack=%b want 1 1 5a5a 040 00",
                         i, bus.o_mem_req, bus.o_mem_we, bus.o_mem_wdata, bus.o_mem_addr, bus.o_ack);
            end
            if (i == 1) set_ch(1, 1'b1, 1'b0, 12'hFFF, 16'h0000);
            if (i == 3) bus.i_mem_ack = 1'b1;
        end
        @(negedge clk);
        total++;
        if ({bus.o_ack, bus.o_err, bus.o_rdata} !== {2'b10, 1'b0, 16'hBEEF}) begin
            bad++;
            $display("FAIL write_ack: got ack=%b err=%b rdata=%h want 10 0 beef",
                     bus.o_ack, bus.o_err, bus.o_rdata);
        end
        set_ch(1, 1'b0, 1'b0, 12'h000, 16'h0000);
        bus.i_mem_ack = 1'b0;
        @(negedge clk);
        total++;
        if (bus.o_ack !== 2'b00) begin
            bad++;
            $display("FAIL write_ack_pulse: got ack=%b want 00", bus.o_ack);
        end
    endtask

    task automatic test_round_robin;
        int          exp_ch;
        logic [11:0] exp_addr;
        logic [15:0] exp_rdata;
        set_ch(0, 1'b1, 1'b0, 12'h111, 16'h0000);
        set_ch(1, 1'b1, 1'b0, 12'h222, 16'h0000);
        bus.i_mem_ack = 1'b1;
        for (int t = 0; t < 4; t++) begin
            exp_ch          = t % 2;
            exp_addr        = (exp_ch == 0) ? 12'h111 : 12'h222;
            exp_rdata       = 16'h1000 + 16'(t);
            bus.i_mem_rdata = exp_rdata;
            @(negedge clk);
            total++;
            if ({bus.o_mem_req, bus.o_mem_addr} !== {1'b1, exp_addr}) begin
                bad++;
                $display("FAIL rr_grant[%0d]: got req=%b addr=%h want 1 %h",
                         t, bus.o_mem_req, bus.o_mem_addr, exp_addr);
            end
            @(negedge clk);
            total++;
            if ({bus.o_ack, bus.o_rdata} !== {2'(1 << exp_ch), exp_rdata}) begin
                bad++;
                $display("FAIL rr_ack[%0d]: got ack=%b rdata=%h want %b %h",
                         t, bus.o_ack, bus.o_rdata, 2'(1 << exp_ch), exp_rdata);
            end
            @(negedge clk);
            total++;
            if (bus.o_ack !== 2'b00) begin
                bad++;
                $display("FAIL rr_ack_pulse[%0d]: got ack=%b want 00", t, bus.o_ack);
            end
        end
        bus.i_req     = '0;
        bus.i_mem_ack = 1'b0;
    endtask

    task automatic test_timeout;
        set_ch(0, 1'b1, 1'b0, 12'h0AB, 16'h0000);
        bus.i_mem_ack = 1'b0;
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            total++;
            if ({bus.o_mem_req, bus.o_ack} !== {1'b1, 2'b00}) begin
                bad++;
                $display("FAIL timeout_wait[%0d]: got req=%b ack=%b want 1 00", i, bus.o_mem_req, bus.o_ack);
            end
        end
        @(negedge clk);
        total++;
        if ({bus.o_ack, bus.o_err, bus.o_rdata, bus.o_mem_req} !== {2'b01, 1'b1, 16'hFFFF, 1'b0}) begin
            bad++;
            $display("FAIL timeout_ack: got ack=%b err=%b rdata=%h req=%b want 01 1 ffff 0",
                     bus.o_ack, bus.o_err, bus.o_rdata, bus.o_mem_req);
        end
        set_ch(0, 1'b0, 1'b0, 12'h000, 16'h0000);
        @(negedge clk);
        total++;
        if ({bus.o_ack, bus.o_err, bus.o_mem_req} !== 4'b0000) begin
            bad++;
            $display("FAIL timeout_idle: got ack=%b err=%b req=%b want 00 0 0",
                     bus.o_ack, bus.o_err, bus.o_mem_req);
        end
    endtask

    task automatic test_reset_mid;
        set_ch(1, 1'b1, 1'b0, 12'h333, 16'h0000);
        bus.i_mem_ack = 1'b0;
        @(negedge clk);
        total++;
        if ({bus.o_mem_req, bus.o_mem_addr} !== {1'b1, 12'h333}) begin
            bad++;
            $display("FAIL rstmid_issue: got req=%b addr=%h want 1 333", bus.o_mem_req, bus.o_mem_addr);
        end
        @(negedge clk);
        rst = 1'b1;
        set_ch(1, 1'b0, 1'b0, 12'h000, 16'h0000);
        @(negedge clk);
        total++;
        if ({bus.o_mem_req, bus.o_ack, bus.o_err, bus.o_rdata} !== 20'h0) begin
            bad++;
            $display("FAIL rstmid_clear: got req=%b ack=%b err=%b rdata=%h want 0 00 0 0000",
                     bus.o_mem_req, bus.o_ack, bus.o_err, bus.o_rdata);
        end
        rst = 1'b0;
        set_ch(0, 1'b1, 1'b0, 12'h444, 16'h0000);
        set_ch(1, 1'b1, 1'b0, 12'h555, 16'h0000);
        bus.i_mem_ack   = 1'b1;
        bus.i_mem_rdata = 16'h7777;
        @(negedge clk);
        total++;
        if ({bus.o_mem_req, bus.o_mem_addr} !== {1'b1, 12'h444}) begin
            bad++;
            $display("FAIL rstmid_first_grant: got req=%b addr=%h want 1 444", bus.o_mem_req, bus.o_mem_addr);
        end
        @(negedge clk);
        total++;
        if ({bus.o_ack, bus.o_rdata} !== {2'b01, 16'h7777}) begin
            bad++;
            $display("FAIL rstmid_ack: got ack=%b rdata=%h want 01 7777", bus.o_ack, bus.o_rdata);
        end
        bus.i_req     = '0;
        bus.i_mem_ack = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_stray_ack;
        bus.i_mem_ack   = 1'b1;
        bus.i_mem_rdata = 16'h1234;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            total++;
            if ({bus.o_ack, bus.o_mem_req, bus.o_rdata} !== {2'b00, 1'b0, 16'h7777}) begin
                bad++;
                $display("FAIL stray_ack[%0d]: got ack=%b req=%b rdata=%h want 00 0 7777",
                         i, bus.o_ack, bus.o_mem_req, bus.o_rdata);
            end
        end
        bus.i_mem_ack = 1'b0;
    endtask

    initial begin
        test_reset();
        test_single_read();
        test_write_wait();
        test_round_robin();
        test_timeout();
        test_reset_mid();
        test_stray_ack();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
